// File: rtl/avr_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : avr_cla_pipe_adder
// Description : Pipelined carry look-ahead adder/subtractor for the AVR
//               datapath. The operand is cut into SECT-bit look-ahead
//               sections with a register after each one, so the carry moves
//               one section per enabled clock. Sustains one operation per
//               cycle and produces AVR-style C, V and Z flags.
// Ports       : cp2      - clock, rising edge
//               ireset   - asynchronous active-high reset
//               en       - pipeline advance enable (0 freezes all registers)
//               in_vld   - operands valid, sampled when en=1
//               sub      - 0: a+b+ci, 1: a-b-ci
//               a, b     - WIDTH-bit operands
//               ci       - carry-in (add) / borrow-in (sub)
//               s        - WIDTH-bit result
//               co       - carry-out (add) / borrow-out (sub)
//               ov       - two's-complement overflow
//               z        - result is zero
//               out_vld  - s/co/ov/z valid
// Revision    : 1.0 - initial release
// ============================================================================
module avr_cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SECT  = 8
) (
  input  logic             cp2,
  input  logic             ireset,
  input  logic             en,
  input  logic             in_vld,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov,
  output logic             z,
  output logic             out_vld
);

  localparam int NS    = WIDTH / SECT;
  // Deskew storage: stage k keeps the (k+1) low sections computed so far.
  localparam int SUM_W = SECT * NS * (NS + 1) / 2;
  // Skew storage: stage k (k < NS-1) keeps operand sections k+1..NS-1.
  localparam int OPQ_W = (NS > 1) ? SECT * NS * (NS - 1) / 2 : 1;

  // Base of the operand window consumed by stage k (k >= 1).
  function automatic int opq_off(input int k);
    return SECT * ((k - 1) * NS - ((k - 1) * k) / 2);
  endfunction

  // Base of the partial-sum window held by stage k.
  function automatic int sum_off(input int k);
    return SECT * ((k * (k + 1)) / 2);
  endfunction

  // SECT-bit generate/propagate look-ahead section.
  // Returns {carry into MSB, carry out, sum}.
  function automatic logic [SECT+1:0] cla(input logic [SECT-1:0] x,
                                          input logic [SECT-1:0] y,
                                          input logic            cin);
    logic [SECT-1:0] g;
    logic [SECT-1:0] p;
    logic [SECT:0]   c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    for (int i = 0; i < SECT; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[SECT-1], c[SECT], p ^ c[SECT-1:0]};
  endfunction

  logic [NS-1:0]    vld_q, vld_d;
  logic [NS-1:0]    sub_q, sub_d;
  logic [NS-1:0]    cy_q, cy_d;
  logic [NS-1:0]    zr_q, zr_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [OPQ_W-1:0] opa_q, opa_d;
  logic [OPQ_W-1:0] opb_q, opb_d;
  logic             ov_q, ov_d;

  // Per-stage section inputs, gathered before the section logic runs.
  logic [NS-1:0][SECT-1:0] st_a;
  logic [NS-1:0][SECT-1:0] st_b;
  logic [NS-1:0]           st_sub;
  logic [NS-1:0]           st_cin;
  logic [NS-1:0]           st_z;
  logic [SECT+1:0]         st_res;

  always_comb begin
    vld_d  = '0;
    sub_d  = '0;
    cy_d   = '0;
    zr_d   = '0;
    sum_d  = '0;
    opa_d  = '0;
    opb_d  = '0;
    ov_d   = 1'b0;
    st_a   = '0;
    st_b   = '0;
    st_sub = '0;
    st_cin = '0;
    st_z   = '0;
    st_res = '0;

    // Stage 0 takes its section straight from the ports. Subtraction is
    // a + ~b + ~ci, so the internal carry-in is ci XOR sub.
    st_a[0]   = a[SECT-1:0];
    st_b[0]   = b[SECT-1:0];
    st_sub[0] = sub;
    st_cin[0] = ci ^ sub;
    st_z[0]   = 1'b1;
    vld_d[0]  = in_vld;

    // Later stages take the skewed operand slice and the previous carry.
    for (int k = 1; k < NS; k++) begin
      st_a[k]   = opa_q[opq_off(k) +: SECT];
      st_b[k]   = opb_q[opq_off(k) +: SECT];
      st_sub[k] = sub_q[k-1];
      st_cin[k] = cy_q[k-1];
      st_z[k]   = zr_q[k-1];
      vld_d[k]  = vld_q[k-1];
    end

    for (int k = 0; k < NS; k++) begin
      st_res   = cla(st_a[k], st_b[k] ^ {SECT{st_sub[k]}}, st_cin[k]);
      sub_d[k] = st_sub[k];
      cy_d[k]  = st_res[SECT];
      zr_d[k]  = st_z[k] & ~|st_res[SECT-1:0];
      sum_d[sum_off(k) + k * SECT +: SECT] = st_res[SECT-1:0];
      for (int j = 0; j < k * SECT; j++) begin
        sum_d[sum_off(k) + j] = sum_q[sum_off(k-1) + j];
      end
      if (k == NS - 1) begin
        ov_d = st_res[SECT+1] ^ st_res[SECT];
      end
    end

    // Operand skew: each stage forwards the sections it has not yet used.
    for (int j = 0; j < (NS - 1) * SECT; j++) begin
      opa_d[j] = a[SECT + j];
      opb_d[j] = b[SECT + j];
    end
    for (int k = 1; k < NS - 1; k++) begin
      for (int j = 0; j < (NS - 1 - k) * SECT; j++) begin
        opa_d[opq_off(k+1) + j] = opa_q[opq_off(k) + SECT + j];
        opb_d[opq_off(k+1) + j] = opb_q[opq_off(k) + SECT + j];
      end
    end
  end

  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      vld_q <= '0;
      sub_q <= '0;
      cy_q  <= '0;
      zr_q  <= '0;
      sum_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      ov_q  <= 1'b0;
    end else if (en) begin
      vld_q <= vld_d;
      sub_q <= sub_d;
      cy_q  <= cy_d;
      zr_q  <= zr_d;
      sum_q <= sum_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      ov_q  <= ov_d;
    end
  end

  assign s       = sum_q[sum_off(NS-1) +: WIDTH];
  // Borrow is the inverted raw carry when subtracting.
  assign co      = cy_q[NS-1] ^ sub_q[NS-1];
  assign ov      = ov_q;
  assign z       = zr_q[NS-1];
  assign out_vld = vld_q[NS-1];

endmodule
`default_nettype wire

// File: tb/tb_avr_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_avr_cla_pipe_adder
// Description : Self-checking bench for avr_cla_pipe_adder, 16-bit (NS=2)
//               and 32-bit (NS=4) instances, against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avr_cla_pipe_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  typedef struct {
    res_t r;
    int   due;
  } exp_t;

  typedef struct packed {
    int          w;
    logic        sb;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    res_t        e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        v16, sub16, ci16;
  logic [15:0] a16, b16;
  logic        v32, sub32, ci32;
  logic [31:0] a32, b32;

  logic [15:0] s16;
  logic        co16, ov16, z16, vo16;
  logic [31:0] s32;
  logic        co32, ov32, z32, vo32;

  int   checks = 0;
  int   errors = 0;
  int   ecnt   = 0;
  exp_t q16[$];
  exp_t q32[$];
  res_t last16, last32;
  logic lvld16, lvld32;
  vec_t tbl [8];

  avr_cla_pipe_adder #(.WIDTH(16), .SECT(8)) dut16 (
    .cp2(clk), .ireset(rst), .en(en), .in_vld(v16), .sub(sub16),
    .a(a16), .b(b16), .ci(ci16), .s(s16), .co(co16), .ov(ov16), .z(z16),
    .out_vld(vo16)
  );

  avr_cla_pipe_adder #(.WIDTH(32), .SECT(8)) dut32 (
    .cp2(clk), .ireset(rst), .en(en), .in_vld(v32), .sub(sub32),
    .a(a32), .b(b32), .ci(ci32), .s(s32), .co(co32), .ov(ov32), .z(z32),
    .out_vld(vo32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain w-bit arithmetic: carry/borrow from the extra bit, overflow from signs.
  function automatic res_t model(input int w, input logic sb, input logic [31:0] a,
                                 input logic [31:0] b, input logic c);
    logic [32:0] r;
    logic [31:0] m, aa, bb;
    res_t        e;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    aa = a & m;
    bb = b & m;
    if (sb) r = {1'b0, aa} - {1'b0, bb} - {32'h0, c};
    else    r = {1'b0, aa} + {1'b0, bb} + {32'h0, c};
    e.s  = r[31:0] & m;
    e.co = r[w];
    if (sb) e.ov = (aa[w-1] != bb[w-1]) && (e.s[w-1] != aa[w-1]);
    else    e.ov = (aa[w-1] == bb[w-1]) && (e.s[w-1] != aa[w-1]);
    e.z  = (e.s == 32'h0);
    return e;
  endfunction

  task automatic cmp(input string tag, input bit en_e, input bit have, input exp_t head,
                     input res_t act, input logic act_vld,
                     inout res_t last, inout logic lvld, output bit pop);
    logic ev;
    pop = 1'b0;
    if (en_e) begin
      ev = have && (head.due == ecnt);
      chk({tag, " out_vld"}, {63'h0, act_vld}, {63'h0, ev});
      if (ev) begin
        chk({tag, " result"}, {29'h0, act}, {29'h0, head.r});
        last = head.r;
        pop  = 1'b1;
      end
      lvld = ev;
    end else begin
      chk({tag, " held out_vld"}, {63'h0, act_vld}, {63'h0, lvld});
      if (lvld) chk({tag, " held result"}, {29'h0, act}, {29'h0, last});
    end
  endtask

  // Model update at each edge, DUT comparison 1 time unit later.
  always @(posedge clk) begin
    logic rst_e, en_e, pop;
    exp_t h;
    rst_e = rst;
    en_e  = en;
    if (!rst_e && en_e) begin
      ecnt++;
      if (v16) q16.push_back('{model(16, sub16, {16'h0, a16}, {16'h0, b16}, ci16), ecnt + 1});
      if (v32) q32.push_back('{model(32, sub32, a32, b32, ci32), ecnt + 3});
    end
    #1;
    if (rst_e) begin
      chk("reset16 outputs", {28'h0, s16, co16, ov16, z16, vo16}, 64'h0);
      chk("reset32 outputs", {28'h0, s32, co32, ov32, z32, vo32}, 64'h0);
      lvld16 = 1'b0;
      lvld32 = 1'b0;
    end else begin
      h = '{'0, 0};
      if (q16.size() > 0) h = q16[0];
      cmp("dut16", en_e, q16.size() > 0, h, {16'h0, s16, co16, ov16, z16}, vo16,
          last16, lvld16, pop);
      if (pop) void'(q16.pop_front());
      h = '{'0, 0};
      if (q32.size() > 0) h = q32[0];
      cmp("dut32", en_e, q32.size() > 0, h, {s32, co32, ov32, z32}, vo32,
          last32, lvld32, pop);
      if (pop) void'(q32.pop_front());
    end
  end

  task automatic op16(input logic sb, input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    v16 = 1'b1; sub16 = sb; a16 = a; b16 = b; ci16 = c;
  endtask

  task automatic op32(input logic sb, input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    v32 = 1'b1; sub32 = sb; a32 = a; b32 = b; ci32 = c;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      v16 = 1'b0;
      v32 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    v16 = 1'b0; sub16 = 1'b0; ci16 = 1'b0; a16 = '0; b16 = '0;
    v32 = 1'b0; sub32 = 1'b0; ci32 = 1'b0; a32 = '0; b32 = '0;
    lvld16 = 1'b0; lvld32 = 1'b0; last16 = '0; last32 = '0;

    // Hand-computed vectors: {width, sub, a, b, ci, {s, co, ov, z}}
    tbl[0] = '{16, 1'b0, 32'h00FF, 32'h0001, 1'b0, {32'h0100, 1'b0, 1'b0, 1'b0}};
    tbl[1] = '{16, 1'b0, 32'hFFFF, 32'h0001, 1'b0, {32'h0000, 1'b1, 1'b0, 1'b1}};
    tbl[2] = '{16, 1'b0, 32'h7FFF, 32'h0001, 1'b0, {32'h8000, 1'b0, 1'b1, 1'b0}};
    tbl[3] = '{16, 1'b1, 32'h0000, 32'h0001, 1'b0, {32'hFFFF, 1'b1, 1'b0, 1'b0}};
    tbl[4] = '{16, 1'b1, 32'h8000, 32'h0001, 1'b0, {32'h7FFF, 1'b0, 1'b1, 1'b0}};
    tbl[5] = '{16, 1'b1, 32'h1234, 32'h1233, 1'b1, {32'h0000, 1'b0, 1'b0, 1'b1}};
    tbl[6] = '{32, 1'b0, 32'h00FF_FFFF, 32'h1, 1'b0, {32'h0100_0000, 1'b0, 1'b0, 1'b0}};
    tbl[7] = '{32, 1'b1, 32'h0, 32'h1, 1'b0, {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};

    #1;
    chk("initial reset16", {28'h0, s16, co16, ov16, z16, vo16}, 64'h0);
    chk("initial reset32", {28'h0, s32, co32, ov32, z32, vo32}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Pin the model to the hand-computed values.
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("model vec%0d", i), {29'h0, model(tbl[i].w, tbl[i].sb, tbl[i].a, tbl[i].b, tbl[i].c)},
          {29'h0, tbl[i].e});
    end

    // Directed 16-bit vectors, back to back.
    for (int i = 0; i < 6; i++) op16(tbl[i].sb, tbl[i].a[15:0], tbl[i].b[15:0], tbl[i].c);
    idle(3);

    // Stream with a one-cycle stall after the second operation; the third
    // operation is already presented during the stall and must be ignored.
    op16(1'b0, 16'h0001, 16'h0001, 1'b0);
    op16(1'b0, 16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    en = 1'b0; v16 = 1'b1; sub16 = 1'b0; a16 = 16'hFFFF; b16 = 16'h0001; ci16 = 1'b0;
    @(negedge clk);
    en = 1'b1;
    idle(4);

    // Reset with operations in flight.
    op16(1'b0, 16'h0011, 16'h0022, 1'b0);
    op16(1'b0, 16'h0100, 16'h0200, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset out_vld", {63'h0, vo16}, 64'h0);
    chk("async reset s", {48'h0, s16}, 64'h0);
    q16.delete();
    lvld16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    v16 = 1'b1; sub16 = 1'b0; a16 = 16'h0003; b16 = 16'h0004; ci16 = 1'b0;
    idle(4);

    // 32-bit directed then a continuous random stream.
    op32(tbl[6].sb, tbl[6].a, tbl[6].b, tbl[6].c);
    op32(tbl[7].sb, tbl[7].a, tbl[7].b, tbl[7].c);
    for (int i = 0; i < 300; i++) begin
      op32(1'($urandom_range(0, 1)), $urandom(), $urandom(), 1'($urandom_range(0, 1)));
    end
    idle(8);

    chk("dut16 drained", q16.size(), 64'h0);
    chk("dut32 drained", q32.size(), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/avr_cla_pipe_adder.md
# avr_cla_pipe_adder

Parametrised, pipelined carry look-ahead adder/subtractor for the AVR datapath and its 16/32-bit extension units. The operand is split into equal-width look-ahead sections; a pipeline register sits after each section, so the carry ripples one section per clock and the block sustains one operation per cycle. It produces sum/difference plus AVR-style C, V and Z flags, with a valid handshake and a global stall.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SECT.
- SECT, 8, width of one look-ahead section; NS = WIDTH/SECT sections (NS >= 1).

Ports:
- cp2  input  1  clock; all registers update on its rising edge.
- ireset  input  1  reset; asynchronous and active-high.
- en  input  1  pipeline advance enable; 0 freezes every register.
- in_vld  input  1  operands valid this cycle; sampled when en=1.
- sub  input  1  0 = A+B+ci (ADD/ADC); 1 = A-B-ci (SUB/SBC).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in when sub=0, borrow-in when sub=1.
- s  output  WIDTH  result.
- co  output  1  carry-out when sub=0, borrow-out when sub=1.
- ov  output  1  two's-complement overflow.
- z  output  1  1 when s == 0.
- out_vld  output  1  s/co/ov/z valid this cycle.

## Operation
- Section k (k = 0..NS-1) covers bits [k*SECT+SECT-1 : k*SECT] and is a SECT-bit CLA.
- Subtract: section operand B is bitwise inverted; internal carry into section 0 is ~ci; co = ~(carry out of section NS-1).
- Add: carry into section 0 is ci; co = carry out of section NS-1.
- Input skew: the slice of a, b feeding section k is delayed k stages, so it meets the carry from section k-1 of the same operation. sub and in_vld travel with each stage.
- Output deskew: the sum of section k is delayed NS-1-k further stages, so all slices of s emerge together.
- ov = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, raw internal carries, computed in stage NS-1.
- z: a running zero bit travels with the operation, ANDed with (section sum == 0) at each stage.
- Each pipeline stage holds its own valid bit. out_vld is the valid bit of the last stage.
- en=0: no register changes, including valid bits. in_vld is ignored and outputs hold their values.
- Stage register contents are don't-care when their valid bit is 0. Outputs are meaningful only with out_vld=1.
- NS=1 degenerates to a single registered CLA with latency 1.

## Timing
- Latency NS enabled cycles from acceptance (in_vld=1, en=1 at edge t) to out_vld=1 after edge t+NS-1. For the default parameters (NS=2) this is 2 cycles.
- Throughput: one operation per enabled cycle; back-to-back operations with no bubbles.
- Each cycle with en=0 adds exactly one cycle to the latency of every in-flight operation. Ordering is always preserved.
- Reset (asynchronous, any time): all stage valids = 0 and all data/flag registers = 0.
  - Outputs after reset: s=0, co=0, ov=0, z=0, out_vld=0.
  - Operations in flight at reset are discarded, never emitted.
- Release of ireset takes effect at the next edge. An operation presented on that edge is accepted normally.
- Critical path: one SECT-bit CLA plus flag/deskew logic. No combinational path from inputs to outputs.

## Test plan
- Defaults (WIDTH=16, SECT=8), add, a=0x00FF, b=0x0001, ci=0 → two cycles later: s=0x0100, co=0, ov=0, z=0, out_vld=1 for exactly one cycle.
- Add, a=0xFFFF, b=0x0001, ci=0 → s=0x0000, co=1, z=1, ov=0. Add, a=0x7FFF, b=0x0001 → s=0x8000, ov=1, co=0, z=0.
- Sub, a=0x0000, b=0x0001, ci=0 → s=0xFFFF, co=1, ov=0. Sub, a=0x8000, b=0x0001, ci=0 → s=0x7FFF, co=0, ov=1. Sub, a=0x1234, b=0x1233, ci=1 → s=0x0000, z=1, co=0.
- Stream of 3 back-to-back operations (0x0001+0x0001, 0x00FF+0x0001, 0xFFFF+0x0001), with en=0 for one cycle after the second is accepted:
  - results 0x0002, 0x0100, 0x0000 appear in order;
  - each result appears one cycle later than without the stall;
  - outputs hold stable during the stall cycle.
- Assert ireset while two operations are in flight → out_vld=0 and s=0 immediately. After release, no stale result appears. A new operation completes with normal latency.
- WIDTH=32, SECT=8 (latency 4):
  - add a=0x00FFFFFF, b=0x00000001 → s=0x01000000, co=0;
  - sub a=0x00000000, b=0x00000001 → s=0xFFFFFFFF, co=1;
  - continuous random stream checked against a reference model, one result per cycle.
